// File: rtl/rbm_gibbs_engine.sv
`default_nettype none
// ============================================================================
// Module      : rbm_gibbs_engine
// Description : Restricted-Boltzmann-machine Gibbs sampler. Each iteration
//               samples H_DIM hidden units from the image, then OUT_DIM class
//               units from the hidden vector, and accumulates saturating
//               per-class vote counters. Optional argmax of the votes is
//               enabled by defining RBM_ARGMAX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_gibbs_engine #(
    parameter int          IN_DIM    = 15,
    parameter int          H_DIM     = 5,
    parameter int          OUT_DIM   = 2,
    parameter int          IN_W      = 12,
    parameter int          PROB_W    = 8,
    parameter int          SIG_SHIFT = 2,
    parameter int          ACC_W     = 12,
    parameter int          ITER_W    = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ITER_W-1:0]               n_iter_i,
    input  logic [IN_DIM*IN_W-1:0]          image_i,
    input  logic [IN_DIM*H_DIM*IN_W-1:0]    h_weight_i,
    input  logic [H_DIM*IN_W-1:0]           h_bias_i,
    input  logic [H_DIM*OUT_DIM*IN_W-1:0]   c_weight_i,
    input  logic [OUT_DIM*IN_W-1:0]         c_bias_i,
    output logic                            busy,
    output logic                            done,
    output logic [OUT_DIM*ACC_W-1:0]        votes_o,
    output logic [$clog2(OUT_DIM)-1:0]      class_o
);
    // Accumulator wide enough for IN_DIM products plus a bias without overflow
    localparam int C_SUM_W = 2*IN_W + $clog2(IN_DIM+H_DIM+1);
    localparam int C_IW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int C_JW    = (H_DIM > 1) ? $clog2(H_DIM) : 1;
    localparam int C_KW    = $clog2(OUT_DIM);
    localparam logic signed [C_SUM_W-1:0] C_HALF = C_SUM_W'(2**(PROB_W-1));
    localparam logic signed [C_SUM_W-1:0] C_FULL = C_SUM_W'(2**PROB_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_H_ACC = 3'd1,
        S_H_SMP = 3'd2,
        S_C_ACC = 3'd3,
        S_C_SMP = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t                      r_state;
    logic signed [C_SUM_W-1:0]   r_acc;
    logic [C_IW-1:0]             r_i;
    logic [C_JW-1:0]             r_j;
    logic [C_KW-1:0]             r_k;
    logic [ITER_W-1:0]           r_iter;
    logic [ITER_W-1:0]           r_n_iter;
    logic [H_DIM-1:0]            r_h;
    logic [15:0]                 r_lfsr;
    logic [OUT_DIM*ACC_W-1:0]    r_votes;
    logic                        r_busy;
    logic                        r_done;

    logic signed [IN_W-1:0]      w_img;
    logic signed [IN_W-1:0]      w_hw;
    logic signed [IN_W-1:0]      w_cw;
    logic signed [2*IN_W-1:0]    w_prod;
    logic signed [C_SUM_W-1:0]   w_shr;
    logic signed [C_SUM_W-1:0]   w_off;
    logic [PROB_W:0]             w_p;
    logic                        w_bit;
    logic [15:0]                 w_lfsr_nxt;
    logic [ACC_W-1:0]            w_vote_cur;
    logic [C_JW-1:0]             w_jn;
    logic [C_KW-1:0]             w_kn;

    function automatic logic signed [C_SUM_W-1:0] f_sext(input logic signed [IN_W-1:0] v);
        return {{(C_SUM_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    // Operand selection straight from the caller-held arrays
    assign w_img  = image_i[r_i*IN_W +: IN_W];
    assign w_hw   = h_weight_i[(r_i*H_DIM + r_j)*IN_W +: IN_W];
    assign w_cw   = c_weight_i[(r_j*OUT_DIM + r_k)*IN_W +: IN_W];
    assign w_prod = w_img * w_hw;

    // Next-bias indices are clamped so no select ever reaches past the array
    assign w_jn = (r_j == C_JW'(H_DIM-1))   ? '0 : r_j + 1'b1;
    assign w_kn = (r_k == C_KW'(OUT_DIM-1)) ? '0 : r_k + 1'b1;

    // Piecewise-linear sigmoid: shifted sum centred on half scale, clamped to [0, 2^PROB_W]
    assign w_shr = r_acc >>> SIG_SHIFT;
    assign w_off = w_shr + C_HALF;
    always_comb begin
        if (w_off[C_SUM_W-1])      w_p = '0;
        else if (w_off > C_FULL)   w_p = C_FULL[PROB_W:0];
        else                       w_p = w_off[PROB_W:0];
    end
    assign w_bit = ({1'b0, r_lfsr[PROB_W-1:0]} < w_p);

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    assign w_vote_cur = r_votes[r_k*ACC_W +: ACC_W];

    // Sequencer: accumulate, sample, vote; all outputs registered here
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_iter   <= '0;
            r_n_iter <= '0;
            r_h      <= '0;
            r_lfsr   <= SEED;
            r_votes  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n_iter <= n_iter_i;
                        r_votes  <= '0;
                        r_acc    <= f_sext(h_bias_i[0 +: IN_W]);
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_iter   <= '0;
                        if (n_iter_i == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_H_ACC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_H_ACC: begin
                    r_acc <= r_acc + {{(C_SUM_W-2*IN_W){w_prod[2*IN_W-1]}}, w_prod};
                    if (r_i == C_IW'(IN_DIM-1)) begin
                        r_i     <= '0;
                        r_state <= S_H_SMP;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_H_SMP: begin
                    r_h[r_j] <= w_bit;
                    r_lfsr   <= w_lfsr_nxt;
                    r_j      <= w_jn;
                    if (r_j == C_JW'(H_DIM-1)) begin
                        r_k     <= '0;
                        r_acc   <= f_sext(c_bias_i[0 +: IN_W]);
                        r_state <= S_C_ACC;
                    end else begin
                        r_acc   <= f_sext(h_bias_i[w_jn*IN_W +: IN_W]);
                        r_state <= S_H_ACC;
                    end
                end
                S_C_ACC: begin
                    if (r_h[r_j]) r_acc <= r_acc + f_sext(w_cw);
                    r_j <= w_jn;
                    if (r_j == C_JW'(H_DIM-1)) r_state <= S_C_SMP;
                end
                S_C_SMP: begin
                    r_lfsr <= w_lfsr_nxt;
                    if (w_bit && (w_vote_cur != {ACC_W{1'b1}}))
                        r_votes[r_k*ACC_W +: ACC_W] <= w_vote_cur + 1'b1;
                    r_k <= w_kn;
                    if (r_k == C_KW'(OUT_DIM-1)) begin
                        if (r_iter == r_n_iter - 1'b1) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_iter  <= r_iter + 1'b1;
                            r_acc   <= f_sext(h_bias_i[0 +: IN_W]);
                            r_state <= S_H_ACC;
                        end
                    end else begin
                        r_acc   <= f_sext(c_bias_i[w_kn*IN_W +: IN_W]);
                        r_state <= S_C_ACC;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign votes_o = r_votes;

`ifdef RBM_ARGMAX_EN
    logic [ACC_W-1:0] w_best_val;
    logic [C_KW-1:0]  w_best_idx;

    // Argmax over the vote counters; strict compare keeps the lowest index on ties
    always_comb begin
        w_best_val = r_votes[0 +: ACC_W];
        w_best_idx = '0;
        for (int k = 1; k < OUT_DIM; k++) begin
            if (r_votes[k*ACC_W +: ACC_W] > w_best_val) begin
                w_best_val = r_votes[k*ACC_W +: ACC_W];
                w_best_idx = C_KW'(k);
            end
        end
    end
    assign class_o = w_best_idx;
`else
    assign class_o = '0;
`endif

endmodule
`default_nettype wire
